// File: rtl/test_stream_source_if.sv
// AXI4-Stream link carrying packed {chB, chA} samples from the test source to its sink.
interface test_stream_source_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/test_stream_source.sv
// Quadrature triangle-wave AXI4-Stream source for bring-up of the downstream signal chain.
// Sample registered at load; tvalid one cycle after enable; output held stable while tready is low.
module test_stream_source #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  TS_enable,
  input  logic [4:0]            TS_log_period,
  input  logic [2:0]            TS_shift,
  input  logic [15:0]           TS_offset,
  input  logic [15:0]           TS_rate_div,
  output logic [31:0]           TS_sample_count,
  test_stream_source_if.master  M_AXIS
);

  typedef enum logic [1:0] {S_IDLE, S_VALID, S_WAIT} state_e;

  state_e                      state_q, state_d;
  logic [15:0]                 phase_q, phase_d;
  logic [15:0]                 step_q, step_d;
  logic [15:0]                 rate_q, rate_d;
  logic [31:0]                 count_q, count_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        tlast_q, tlast_d;
  logic [4:0]                  lp_clamp;
  logic [15:0]                 step_new;
  logic [16:0]                 phase_sum;
  logic                        hs;
  logic                        load;

  // Triangle in -16384..16383, attenuated, offset and saturated to 16 bits.
  function automatic logic [15:0] tri_wave(input logic [15:0] p,
                                           input logic [2:0]  sh,
                                           input logic [15:0] off);
    logic [14:0]        t;
    logic signed [17:0] s;
    logic signed [17:0] v;
    t = p[15] ? ~p[14:0] : p[14:0];
    s = $signed({3'b000, t}) - 18'sd16384;
    v = (s >>> sh) + $signed({{2{off[15]}}, off});
    if (v > 18'sd32767) begin
      return 16'h7FFF;
    end else if (v < -18'sd32768) begin
      return 16'h8000;
    end
    return v[15:0];
  endfunction

  always_comb begin
    if (TS_log_period == 5'd0) begin
      lp_clamp = 5'd1;
    end else if (TS_log_period > 5'd16) begin
      lp_clamp = 5'd16;
    end else begin
      lp_clamp = TS_log_period;
    end
  end

  assign step_new = 16'(17'h10000 >> lp_clamp);
  assign hs       = (state_q == S_VALID) && M_AXIS.tready;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    rate_d    = rate_q;
    count_d   = count_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    load      = 1'b0;
    phase_sum = 17'd0;

    case (state_q)
      S_IDLE: begin
        phase_d = 16'd0;
        if (TS_enable) begin
          load    = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (hs) begin
          count_d = count_q + 32'd1;
          phase_d = phase_q + step_q;
          if (!TS_enable) begin
            state_d = S_IDLE;
            phase_d = 16'd0;
          end else if (TS_rate_div == 16'd0) begin
            load = 1'b1;
          end else begin
            state_d = S_WAIT;
            rate_d  = TS_rate_div;
          end
        end
      end
      S_WAIT: begin
        rate_d = rate_q - 16'd1;
        if (!TS_enable) begin
          state_d = S_IDLE;
          phase_d = 16'd0;
        end else if (rate_q <= 16'd1) begin
          load    = 1'b1;
          state_d = S_VALID;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The loaded sample reflects the phase after any advance this cycle.
    if (load) begin
      step_d    = step_new;
      phase_sum = {1'b0, phase_d} + {1'b0, step_new};
      tlast_d   = phase_sum[16];
      tdata_d   = AXIS_TDATA_WIDTH'({tri_wave(phase_d + 16'h4000, TS_shift, TS_offset),
                                     tri_wave(phase_d, TS_shift, TS_offset)});
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      phase_q <= 16'd0;
      step_q  <= 16'd0;
      rate_q  <= 16'd0;
      count_q <= 32'd0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      rate_q  <= rate_d;
      count_q <= count_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
    end
  end

  assign M_AXIS.tvalid   = (state_q == S_VALID);
  assign M_AXIS.tdata    = tdata_q;
  assign M_AXIS.tlast    = tlast_q;
  assign TS_sample_count = count_q;

endmodule

// File: tb/tb_test_stream_source.sv
// Scoreboard bench for test_stream_source: expected samples queued at stimulus time, checked on the stream.
module tb_test_stream_source;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  logic        aclk;
  logic        aresetn;
  logic        TS_enable;
  logic [4:0]  TS_log_period;
  logic [2:0]  TS_shift;
  logic [15:0] TS_offset;
  logic [15:0] TS_rate_div;
  logic [31:0] TS_sample_count;

  test_stream_source_if #(.W(32)) m_axis ();

  test_stream_source #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .TS_enable       (TS_enable),
    .TS_log_period   (TS_log_period),
    .TS_shift        (TS_shift),
    .TS_offset       (TS_offset),
    .TS_rate_div     (TS_rate_div),
    .TS_sample_count (TS_sample_count),
    .M_AXIS          (m_axis)
  );

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  int   exp_count;
  int   ready_mode;
  logic mon_en;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tri_w(int p);
    return (p < 32768) ? (p - 16384) : ((65535 - p) - 16384);
  endfunction

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int step_of(int lp);
    int l;
    l = (lp < 1) ? 1 : ((lp > 16) ? 16 : lp);
    return 1 << (16 - l);
  endfunction

  function automatic logic [31:0] model_dat(int ph, int sh, int off);
    int a;
    int b;
    a = sat16((tri_w(ph) >>> sh) + off);
    b = sat16((tri_w((ph + 16384) % 65536) >>> sh) + off);
    return {b[15:0], a[15:0]};
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic l);
    exp_t e;
    e.dat  = d;
    e.last = l;
    sb.push_back(e);
  endtask

  // tready: 0 -> always 1, 1 -> repeating 1,0,0,1, otherwise held low
  initial begin
    logic [3:0] pat;
    int         ridx;
    pat          = 4'b1001;
    ridx         = 0;
    m_axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      case (ready_mode)
        0: m_axis.tready = 1'b1;
        1: begin
          m_axis.tready = pat[ridx];
          ridx = (ridx + 1) % 4;
        end
        default: m_axis.tready = 1'b0;
      endcase
    end
  end

  // Every visible sample must match the queue head; pop only on handshake.
  always @(negedge aclk) begin
    if (aresetn && mon_en && m_axis.tvalid) begin
      if (sb.size() == 0) begin
        chk("extra_sample", 64'd1, 64'd0);
      end else begin
        chk("tdata", 64'(m_axis.tdata), 64'(sb[0].dat));
        chk("tlast", 64'(m_axis.tlast), 64'(sb[0].last));
        if (m_axis.tready) void'(sb.pop_front());
      end
    end
  end

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic settle_check(input string tag);
    repeat (2) @(negedge aclk);
    #1;
    chk({tag, "_count"}, 64'(TS_sample_count), 64'(exp_count));
    chk({tag, "_idle"}, 64'(m_axis.tvalid), 64'd0);
  endtask

  task automatic run_seq(input string tag, input int n, input logic [4:0] lp,
                         input logic [2:0] sh, input logic [15:0] off);
    int ph;
    int st;
    int offi;
    @(posedge aclk);
    #1;
    TS_log_period = lp;
    TS_shift      = sh;
    TS_offset     = off;
    TS_rate_div   = 16'd0;
    st   = step_of(int'(lp));
    offi = int'($signed(off));
    ph   = 0;
    for (int i = 0; i < n; i++) begin
      push_exp(model_dat(ph, int'(sh), offi), (ph + st) > 65535);
      ph = (ph + st) % 65536;
    end
    exp_count += n;
    TS_enable = 1'b1;
    wait_empty(n * 8 + 20);
    TS_enable = 1'b0;
    settle_check(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_count     = 0;
    ready_mode    = 0;
    mon_en        = 1'b1;
    aresetn       = 1'b0;
    TS_enable     = 1'b0;
    TS_log_period = 5'd2;
    TS_shift      = 3'd0;
    TS_offset     = 16'd0;
    TS_rate_div   = 16'd0;

    #12;
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis.tdata), 64'd0);
    chk("rst_tlast", 64'(m_axis.tlast), 64'd0);
    chk("rst_count", 64'(TS_sample_count), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Basic quarter-period sequence, two full periods back to back
    @(posedge aclk);
    #1;
    for (int r = 0; r < 2; r++) begin
      push_exp(32'h0000C000, 1'b0);
      push_exp(32'h3FFF0000, 1'b0);
      push_exp(32'hFFFF3FFF, 1'b0);
      push_exp(32'hC000FFFF, 1'b1);
    end
    exp_count += 8;
    TS_enable = 1'b1;
    wait_empty(40);
    TS_enable = 1'b0;
    settle_check("basic");
    chk("basic_count8", 64'(TS_sample_count), 64'd8);

    // Backpressure with tready 1,0,0,1
    ready_mode = 1;
    run_seq("bp", 8, 5'd2, 3'd0, 16'h0000);
    ready_mode = 0;

    // Rate divider: one sample every 4 cycles
    @(posedge aclk);
    #1;
    TS_rate_div = 16'd3;
    push_exp(model_dat(0, 0, 0), 1'b0);
    push_exp(model_dat(16384, 0, 0), 1'b0);
    exp_count += 2;
    TS_enable = 1'b1;
    @(posedge aclk);
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      #1;
      chk($sformatf("rate_vld%0d", i), 64'(m_axis.tvalid), (i % 4 == 0) ? 64'd1 : 64'd0);
    end
    TS_enable   = 1'b0;
    TS_rate_div = 16'd0;
    settle_check("rate");
    chk("rate_sb_empty", 64'(sb.size()), 64'd0);

    // Saturation and attenuation
    run_seq("sat_hi", 3, 5'd2, 3'd0, 16'h7000);
    run_seq("sat_lo", 1, 5'd2, 3'd0, 16'h9000);
    run_seq("shift2", 1, 5'd2, 3'd2, 16'h0000);
    run_seq("mixed", 8, 5'd3, 3'd1, 16'h0123);

    // Enable dropped while stalled: pending sample must complete
    @(posedge aclk);
    #1;
    TS_log_period = 5'd2;
    TS_shift      = 3'd0;
    TS_offset     = 16'd0;
    ready_mode    = 2;
    push_exp(32'h0000C000, 1'b0);
    TS_enable = 1'b1;
    begin
      int n;
      n = 0;
      while (!m_axis.tvalid && n < 10) begin
        @(negedge aclk);
        #1;
        n++;
      end
    end
    TS_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      chk("hold_tvalid", 64'(m_axis.tvalid), 64'd1);
    end
    @(posedge aclk);
    #1;
    ready_mode = 0;
    exp_count += 1;
    wait_empty(10);
    settle_check("drop");

    @(posedge aclk);
    #1;
    push_exp(32'h0000C000, 1'b0);
    exp_count += 1;
    TS_enable = 1'b1;
    wait_empty(10);
    TS_enable = 1'b0;
    settle_check("reenable");

    // Period clamping at both ends
    run_seq("lp0", 4, 5'd0, 3'd0, 16'h0000);
    run_seq("lp31", 6, 5'd31, 3'd0, 16'h0000);

    // Asynchronous reset while a sample is pending
    @(posedge aclk);
    #1;
    ready_mode = 2;
    push_exp(32'h0000C000, 1'b0);
    TS_enable = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    chk("pre_rst_tvalid", 64'(m_axis.tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("async_rst_tdata", 64'(m_axis.tdata), 64'd0);
    chk("async_rst_count", 64'(TS_sample_count), 64'd0);
    sb.delete();
    exp_count  = 0;
    TS_enable  = 1'b0;
    ready_mode = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    run_seq("post_rst", 4, 5'd2, 3'd0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
